// File: rtl/pulse_count_arbiter.sv
// Round-robin arbiter handing one shared pulse counter to four requesters.
// A job ends with done after TARGET owner pulses, or with abort on request drop or idle timeout.
module pulse_count_arbiter #(
    parameter int TARGET  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] pulse,
    output logic [3:0] grant,
    output logic       busy,
    output logic [2:0] count,
    output logic       done,
    output logic       abort,
    output logic [1:0] done_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_COUNT = 3'(TARGET - 1);
    localparam logic [7:0] LAST_TICK  = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [1:0] owner_reg, owner_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] done_id_reg, done_id_next;
    logic [2:0] count_reg, count_next;
    logic [7:0] timer_reg, timer_next;
    logic       done_reg, done_next;
    logic       abort_reg, abort_next;

    // Request vector viewed from ptr upward, so offset 0 has highest priority.
    logic [3:0] rot_req;
    logic [1:0] rot_idx [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = ptr_reg + 2'(gi);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    logic       pick_valid;
    logic [1:0] pick_idx;

    always_comb begin
        pick_valid = |rot_req;
        pick_idx   = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_idx = rot_idx[i];
            end
        end
    end

    logic owner_pulse;
    logic owner_req;

    assign owner_pulse = pulse[owner_reg];
    assign owner_req   = req[owner_reg];

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        done_id_next = done_id_reg;
        count_next   = count_reg;
        timer_next   = timer_reg;
        done_next    = 1'b0;
        abort_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                count_next = 3'd0;
                timer_next = 8'd0;
                if (pick_valid) begin
                    state_next = ACTIVE;
                    owner_next = pick_idx;
                end
            end

            ACTIVE: begin
                // Completion outranks a simultaneous request drop.
                if (owner_pulse && (count_reg == LAST_COUNT)) begin
                    state_next   = RELEASE;
                    done_next    = 1'b1;
                    done_id_next = owner_reg;
                    count_next   = 3'd0;
                    timer_next   = 8'd0;
                end else if (!owner_req) begin
                    state_next   = RELEASE;
                    abort_next   = 1'b1;
                    done_id_next = owner_reg;
                    count_next   = 3'd0;
                    timer_next   = 8'd0;
                end else if (owner_pulse) begin
                    count_next = count_reg + 3'd1;
                    timer_next = 8'd0;
                end else if (timer_reg == LAST_TICK) begin
                    state_next   = RELEASE;
                    abort_next   = 1'b1;
                    done_id_next = owner_reg;
                    count_next   = 3'd0;
                    timer_next   = 8'd0;
                end else begin
                    timer_next = timer_reg + 8'd1;
                end
            end

            RELEASE: begin
                ptr_next   = owner_reg + 2'd1;
                count_next = 3'd0;
                timer_next = 8'd0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                count_next = 3'd0;
                timer_next = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            owner_reg   <= 2'd0;
            ptr_reg     <= 2'd0;
            done_id_reg <= 2'd0;
            count_reg   <= 3'd0;
            timer_reg   <= 8'd0;
            done_reg    <= 1'b0;
            abort_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            done_id_reg <= done_id_next;
            count_reg   <= count_next;
            timer_reg   <= timer_next;
            done_reg    <= done_next;
            abort_reg   <= abort_next;
        end
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_grant
            assign grant[gi] = (state_reg == ACTIVE) && (owner_reg == 2'(gi));
        end
    endgenerate

    assign busy    = (state_reg == ACTIVE);
    assign count   = count_reg;
    assign done    = done_reg;
    assign abort   = abort_reg;
    assign done_id = done_id_reg;

endmodule

// File: tb/tb_pulse_count_arbiter.sv
// Directed bench for pulse_count_arbiter with default TARGET=4, TIMEOUT=16.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_pulse_count_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] pulse;
    logic [3:0] grant;
    logic       busy;
    logic [2:0] count;
    logic       done;
    logic       abort;
    logic [1:0] done_id;

    int total = 0;
    int bad   = 0;

    pulse_count_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pulse   (pulse),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .abort   (abort),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = 4'b0000;
        pulse = 4'b0000;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        req   = 4'b0000;
        pulse = 4'b0000;

        // Reset state, before any clock edge
        #3;
        chk("rst_grant",   32'(grant),   32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_count",   32'(count),   32'h0);
        chk("rst_done",    32'(done),    32'h0);
        chk("rst_abort",   32'(abort),   32'h0);
        chk("rst_done_id", 32'(done_id), 32'h0);
        step();
        rst = 1'b1;

        // Idle with no requests keeps grant at zero
        step();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_busy",  32'(busy),  32'h0);

        // Single requester, four non-consecutive pulses
        req = 4'b0001;
        step();
        chk("a_grant", 32'(grant), 32'h1);
        chk("a_busy",  32'(busy),  32'h1);
        chk("a_count0", 32'(count), 32'h0);
        pulse = 4'b0001; step(); chk("a_count1", 32'(count), 32'h1);
        pulse = 4'b0000; step(); chk("a_hold1",  32'(count), 32'h1);
        pulse = 4'b0001; step(); chk("a_count2", 32'(count), 32'h2);
        pulse = 4'b0000; step(); chk("a_hold2",  32'(count), 32'h2);
        pulse = 4'b0001; step(); chk("a_count3", 32'(count), 32'h3);
        chk("a_no_done", 32'(done), 32'h0);
        pulse = 4'b0000; step();
        pulse = 4'b0001; step();
        chk("a_done",    32'(done),    32'h1);
        chk("a_abort",   32'(abort),   32'h0);
        chk("a_done_id", 32'(done_id), 32'h0);
        chk("a_grant0",  32'(grant),   32'h0);
        chk("a_cnt_rel", 32'(count),   32'h0);
        chk("a_busy_rel",32'(busy),    32'h0);
        pulse = 4'b0000;
        req   = 4'b0000;
        step();
        chk("a_done_low", 32'(done),  32'h0);
        chk("a_idle",     32'(grant), 32'h0);

        // Round robin over four continuous requesters, fifth job wraps to 0
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            int owner;
            owner = j % 4;
            step();
            chk("b_grant", 32'(grant), 32'(1) << owner);
            pulse = 4'(1 << owner);
            for (int k = 1; k < 4; k++) begin
                step();
                chk("b_count", 32'(count), 32'(k));
            end
            step();
            chk("b_done",    32'(done),    32'h1);
            chk("b_done_id", 32'(done_id), 32'(owner));
            chk("b_rel_gnt", 32'(grant),   32'h0);
            pulse = 4'b0000;
            step();
            chk("b_idle_gnt",  32'(grant), 32'h0);
            chk("b_idle_done", 32'(done),  32'h0);
        end

        // Timeout abort for owner 2, then requester 3 takes over
        do_reset();
        req = 4'b1100;
        step();
        chk("c_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 15; k++) begin
            step();
        end
        chk("c_pre_abort", 32'(abort), 32'h0);
        chk("c_pre_busy",  32'(busy),  32'h1);
        step();
        chk("c_abort",   32'(abort),   32'h1);
        chk("c_done",    32'(done),    32'h0);
        chk("c_done_id", 32'(done_id), 32'h2);
        chk("c_count",   32'(count),   32'h0);
        chk("c_grant0",  32'(grant),   32'h0);
        step();
        chk("c_abort_low", 32'(abort), 32'h0);
        step();
        chk("c_next_grant", 32'(grant), 32'h8);

        // Completion and request drop on the same edge gives done
        do_reset();
        req   = 4'b0010;
        step();
        chk("d_grant", 32'(grant), 32'h2);
        pulse = 4'b0010;
        step(); step(); step();
        chk("d_count3", 32'(count), 32'h3);
        req = 4'b0000;
        step();
        chk("d_done",    32'(done),    32'h1);
        chk("d_abort",   32'(abort),   32'h0);
        chk("d_done_id", 32'(done_id), 32'h1);

        // Request drop mid-job aborts
        pulse = 4'b0000;
        req   = 4'b0010;
        step();
        step();
        chk("e_grant", 32'(grant), 32'h2);
        pulse = 4'b0010;
        step();
        chk("e_count1", 32'(count), 32'h1);
        pulse = 4'b0000;
        req   = 4'b0000;
        step();
        chk("e_abort",   32'(abort),   32'h1);
        chk("e_done",    32'(done),    32'h0);
        chk("e_done_id", 32'(done_id), 32'h1);

        // Pulse on the final timer cycle is counted and restarts the timer
        do_reset();
        req = 4'b0001;
        step();
        chk("f_grant", 32'(grant), 32'h1);
        for (int k = 0; k < 15; k++) begin
            step();
        end
        pulse = 4'b0001;
        step();
        chk("f_count",  32'(count), 32'h1);
        chk("f_abort",  32'(abort), 32'h0);
        chk("f_busy",   32'(busy),  32'h1);
        pulse = 4'b0000;
        for (int k = 0; k < 15; k++) begin
            step();
        end
        chk("f_still_busy", 32'(busy), 32'h1);
        step();
        chk("f_abort2", 32'(abort), 32'h1);

        // Asynchronous reset mid-job discards it without a strobe
        do_reset();
        req = 4'b0001;
        step();
        pulse = 4'b0001;
        step(); step();
        chk("g_count2", 32'(count), 32'h2);
        pulse = 4'b0000;
        #3;
        rst = 1'b0;
        #1;
        chk("g_async_grant", 32'(grant), 32'h0);
        chk("g_async_count", 32'(count), 32'h0);
        chk("g_async_busy",  32'(busy),  32'h0);
        step();
        chk("g_no_done",  32'(done),  32'h0);
        chk("g_no_abort", 32'(abort), 32'h0);
        rst = 1'b1;
        req = 4'b0100;
        step();
        chk("g_regrant", 32'(grant), 32'h4);

        // Non-owner pulses are ignored
        do_reset();
        req = 4'b1000;
        step();
        chk("h_grant", 32'(grant), 32'h8);
        pulse = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("h_count", 32'(count), 32'h0);
            chk("h_done",  32'(done),  32'h0);
        end
        chk("h_busy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_count_arbiter.md
PULSE_COUNT_ARBITER -- requirements
Module: pulse_count_arbiter

Interface
REQ-001 SHALL have parameter TARGET, default 4, meaning pulses per job (legal 1-7).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning cycles without a granted pulse before a job aborts (legal 2-255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have port req  input  4  per-requester job request, level.
REQ-006 SHALL have port pulse  input  4  per-requester count input, level, sampled each clock.
REQ-007 SHALL have port grant  output  4  one-hot owner of the counter, all-zero when none.
REQ-008 SHALL have port busy  output  1  high while state is ACTIVE.
REQ-009 SHALL have port count  output  3  pulses counted in the current job.
REQ-010 SHALL have port done  output  1  one-cycle completion strobe.
REQ-011 SHALL have port abort  output  1  one-cycle abort strobe.
REQ-012 SHALL have port done_id  output  2  index of the requester whose job ended, valid with done or abort.

Function
REQ-013 SHALL implement a registered Moore FSM with states IDLE, ACTIVE, RELEASE; all outputs decode from registers only.
REQ-014 IDLE: if any req bit is 1 at an edge, SHALL enter ACTIVE with grant set to the first requester with req=1, searching upward from ptr and wrapping 3->0.
REQ-015 IDLE: SHALL stay in IDLE with grant=0 when req=0000.
REQ-016 Grant latency SHALL be exactly one cycle from the req-sampling edge.
REQ-017 ACTIVE: count SHALL increment by 1 at each edge where pulse[owner]=1; pulse bits of non-owners SHALL be ignored.
REQ-018 ACTIVE: at an edge with pulse[owner]=1 and count=TARGET-1, SHALL enter RELEASE with done=1, done_id=owner, grant=0, count=0.
REQ-019 ACTIVE: at an edge with req[owner]=0, SHALL enter RELEASE with abort=1, done_id=owner, grant=0, count=0.
REQ-020 ACTIVE: an idle timer SHALL clear on each owner pulse, else increment; reaching TIMEOUT-1 without a pulse SHALL cause the abort of REQ-019.
REQ-021 Simultaneous completion and req[owner] drop SHALL yield done, not abort.
REQ-022 Simultaneous final timer cycle and owner pulse SHALL count the pulse and clear the timer; no abort.
REQ-023 RELEASE SHALL last exactly one cycle, SHALL set ptr=owner+1 modulo 4, and SHALL return to IDLE; done and abort SHALL be low in every other state.
REQ-024 count SHALL be 0 outside ACTIVE and SHALL never reach TARGET.
REQ-025 grant SHALL be one-hot or zero at all times; busy SHALL equal (state==ACTIVE).
REQ-026 A requester holding req continuously SHALL be re-granted no sooner than after every other active requester has had one job.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, grant=0000, busy=0, count=0, done=0, abort=0, done_id=0, ptr=0, timer=0, regardless of clk.
REQ-028 Reset asserted mid-job SHALL discard the job with no done or abort strobe.
REQ-029 After rst returns to 1, the first arbitration SHALL happen at the next rising edge.

Verification
REQ-030 req=0001, pulse[0] high 4 non-consecutive cycles -> grant=0001 one cycle after req, count 1,2,3, then done=1 with done_id=0 for one cycle, grant=0000.
REQ-031 req=1111 held, each owner pulses 4 times -> grants in order 0001,0010,0100,1000,0001, with one RELEASE and one IDLE cycle between jobs.
REQ-032 Owner 2 granted, no pulse for 16 cycles -> abort=1, done_id=2, count=0, then next requester granted.
REQ-033 Owner 1 at count=3, pulse[1]=1 and req[1]=0 on the same edge -> done=1, abort=0, done_id=1.
REQ-034 Owner 0 at count=2, rst driven to 0 between edges -> grant=0000, count=0 immediately; after release, req=0100 -> grant=0100 next edge.
REQ-035 Owner 3 granted, pulse=0111 for 5 cycles -> count stays 0, no done.
